// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared constants and types for the instruction-decode stage:
//               opcode values, ALU operation codes, instruction field
//               positions, instruction class enum and the control bundle.
//               The control bundle carries an extra 'illegal' bit when
//               INSTR_DECODE_ILLEGAL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Instruction field positions (opcode is MSB-first in this core)
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 25;
    localparam int F3_MSB  = 14;
    localparam int F3_LSB  = 12;
    localparam int F7_MSB  = 6;
    localparam int F7_LSB  = 0;

    // Major opcodes
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct7 value that turns R-type funct3=000 into a subtract
    localparam logic [6:0] F7_SUB = 7'b0100000;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_RTYPE  = 3'd1,
        CLS_ITYPE  = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5
    } instr_class_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       branch;
        logic       is_rtype;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
`ifdef INSTR_DECODE_ILLEGAL_EN
        logic       illegal;
`endif
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/decode_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decode_alu_ctrl
// Description : Combinational ALU-operation selection from instruction class,
//               funct3 and funct7.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_alu_ctrl
    import decode_pkg::*;
(
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    input  instr_class_t cls,
    output logic [2:0]   alu_op
);

    logic [2:0] f3_op;

    // Shared funct3 table for R-type and I-type ALU instructions
    always_comb begin
        f3_op = ALU_ADD;
        case (funct3)
            3'b000:  f3_op = ALU_ADD;
            3'b001:  f3_op = ALU_SLL;
            3'b010:  f3_op = ALU_SLT;
            3'b011:  f3_op = ALU_SLT;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  f3_op = ALU_SRL;
            3'b110:  f3_op = ALU_OR;
            default: f3_op = ALU_AND;
        endcase
    end

    // Class-dependent override: only R-type honours funct7 for subtract
    always_comb begin
        alu_op = ALU_ADD;
        case (cls)
            CLS_RTYPE:  alu_op = (funct3 == 3'b000 && funct7 == F7_SUB) ? ALU_SUB : f3_op;
            CLS_ITYPE:  alu_op = f3_op;
            CLS_BRANCH: alu_op = ALU_SUB;
            default:    alu_op = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode
// Description : Registered instruction-decode pipeline stage. Classifies the
//               instruction by opcode, generates datapath strobes and the
//               ALU op, and registers them behind an enable.
//               Optional macro INSTR_DECODE_ILLEGAL_EN adds an 'illegal'
//               output flagging unknown opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [XLEN-1:0] instruction,
    output logic [2:0]      ALUop,
    output logic            reg_write,
    output logic            mem_write,
    output logic            mem_read,
    output logic            mem_to_reg,
    output logic            branch,
    output logic            is_rtype,
    output logic            is_itype_load,
    output logic            is_itype_store,
`ifdef INSTR_DECODE_ILLEGAL_EN
    output logic            illegal,
`endif
    output logic            is_branch
);

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    instr_class_t cls;
    logic [2:0]   alu_op;
    ctrl_t        nxt;
    ctrl_t        ctrl_q;

    assign opcode = instruction[OPC_MSB:OPC_LSB];
    assign funct3 = instruction[F3_MSB:F3_LSB];
    assign funct7 = instruction[F7_MSB:F7_LSB];

    // Operand/immediate fields are consumed further down the pipe, not here
    logic unused_fields;
    assign unused_fields = ^{instruction[24:15], instruction[11:7]};

    // Opcode to instruction class
    always_comb begin
        cls = CLS_NONE;
        case (opcode)
            OPC_RTYPE:  cls = CLS_RTYPE;
            OPC_ITYPE:  cls = CLS_ITYPE;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            default:    cls = CLS_NONE;
        endcase
    end

    decode_alu_ctrl u_alu_ctrl (
        .funct3 (funct3),
        .funct7 (funct7),
        .cls    (cls),
        .alu_op (alu_op)
    );

    // Class to control strobes; unknown opcodes become an all-zero bubble
    always_comb begin
        nxt        = '0;
        nxt.alu_op = alu_op;
        case (cls)
            CLS_RTYPE: begin
                nxt.is_rtype  = 1'b1;
                nxt.reg_write = 1'b1;
            end
            CLS_ITYPE: begin
                nxt.reg_write = 1'b1;
            end
            CLS_LOAD: begin
                nxt.is_load    = 1'b1;
                nxt.reg_write  = 1'b1;
                nxt.mem_read   = 1'b1;
                nxt.mem_to_reg = 1'b1;
            end
            CLS_STORE: begin
                nxt.is_store  = 1'b1;
                nxt.mem_write = 1'b1;
            end
            CLS_BRANCH: begin
                nxt.is_branch = 1'b1;
                nxt.branch    = 1'b1;
            end
            default: begin
`ifdef INSTR_DECODE_ILLEGAL_EN
                nxt.illegal = 1'b1;
`endif
            end
        endcase
    end

    // Pipeline register: async clear, load only when the stage is enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else if (en) begin
            ctrl_q <= nxt;
        end
    end

    assign ALUop          = ctrl_q.alu_op;
    assign reg_write      = ctrl_q.reg_write;
    assign mem_write      = ctrl_q.mem_write;
    assign mem_read       = ctrl_q.mem_read;
    assign mem_to_reg     = ctrl_q.mem_to_reg;
    assign branch         = ctrl_q.branch;
    assign is_rtype       = ctrl_q.is_rtype;
    assign is_itype_load  = ctrl_q.is_load;
    assign is_itype_store = ctrl_q.is_store;
    assign is_branch      = ctrl_q.is_branch;
`ifdef INSTR_DECODE_ILLEGAL_EN
    assign illegal        = ctrl_q.illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_decode
// Description : Self-checking bench for instr_decode: directed steps followed
//               by randomized instructions compared against a reference model.
//               Honours INSTR_DECODE_ILLEGAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] instruction;
    logic [2:0]  ALUop;
    logic        reg_write, mem_write, mem_read, mem_to_reg, branch;
    logic        is_rtype, is_itype_load, is_itype_store, is_branch;
    logic        ill_bit;

    int total = 0;
    int bad   = 0;

    // {ALUop[12:10], reg_write, mem_write, mem_read, mem_to_reg, branch,
    //  is_rtype, load, store, is_branch, illegal[0]}
    logic [12:0] obs;
    logic [12:0] exp_v;

`ifdef INSTR_DECODE_ILLEGAL_EN
    logic illegal;
    assign ill_bit = illegal;
`else
    assign ill_bit = 1'b0;
`endif

    instr_decode #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .instruction    (instruction),
        .ALUop          (ALUop),
        .reg_write      (reg_write),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_to_reg     (mem_to_reg),
        .branch         (branch),
        .is_rtype       (is_rtype),
        .is_itype_load  (is_itype_load),
        .is_itype_store (is_itype_store),
`ifdef INSTR_DECODE_ILLEGAL_EN
        .illegal        (illegal),
`endif
        .is_branch      (is_branch)
    );

    assign obs = {ALUop, reg_write, mem_write, mem_read, mem_to_reg, branch,
                  is_rtype, is_itype_load, is_itype_store, is_branch, ill_bit};

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [6:0] f7);
        return {opc, 10'h155, f3, 5'h0A, f7};
    endfunction

    // Reference decode straight from the instruction-set rules
    function automatic logic [12:0] model(input logic [31:0] ins);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] alu_tab [8];
        logic [2:0] a;
        logic rw, mw, mr, m2r, br, rt, ld, st, ib, il;
        opc = ins[31:25];
        f3  = ins[14:12];
        f7  = ins[6:0];
        alu_tab = '{3'd0, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        a = 3'd0; rw = 0; mw = 0; mr = 0; m2r = 0; br = 0; rt = 0; ld = 0; st = 0; ib = 0; il = 0;
        case (opc)
            7'b0110011: begin
                rt = 1; rw = 1;
                a = (f3 == 3'd0 && f7 == 7'b0100000) ? 3'd1 : alu_tab[f3];
            end
            7'b0010011: begin rw = 1; a = alu_tab[f3]; end
            7'b0000011: begin ld = 1; rw = 1; mr = 1; m2r = 1; end
            7'b0100011: begin st = 1; mw = 1; end
            7'b1100011: begin ib = 1; br = 1; a = 3'd1; end
            default: begin
`ifdef INSTR_DECODE_ILLEGAL_EN
                il = 1;
`endif
            end
        endcase
        return {a, rw, mw, mr, m2r, br, rt, ld, st, ib, il};
    endfunction

    task automatic check(input string tag);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
        end
        total++;
        assert ($countones(obs[4:1]) <= 1 && !(obs[8] && obs[7]))
        else begin
            bad++;
            $error("FAIL %s_invariant: observed=%b expected=onehot0 class, no rd+wr", tag, obs);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic e, input string tag);
        @(negedge clk);
        instruction = ins;
        en          = e;
        @(posedge clk);
        #1;
        if (e) exp_v = model(ins);
        check(tag);
    endtask

    initial begin
        logic [6:0] opcs [5];
        logic [6:0] opc;
        logic [31:0] ins;
        opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

        // Asynchronous reset with an all-ones instruction presented
        rst_n       = 1'b0;
        en          = 1'b1;
        instruction = 32'hFFFF_FFFF;
        #1;
        exp_v = '0;
        check("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check("reset_held");

        // Release; the next edge decodes the present instruction
        @(negedge clk);
        rst_n = 1'b1;
        step(32'b0110011_00000_00001_000_00000_1000011, 1'b1, "rtype_add");
        step(32'b0010011_00010_00010_000_00010_1000011, 1'b1, "itype_add");
        step(mk(7'b0000011, 3'b010, 7'h11), 1'b1, "load");
        step(mk(7'b0100011, 3'b010, 7'h22), 1'b1, "store");
        step(mk(7'b1100011, 3'b000, 7'h63), 1'b1, "branch");
        step(mk(7'b0110011, 3'b000, 7'b0100000), 1'b1, "rtype_sub");
        step(mk(7'b0010011, 3'b000, 7'b0100000), 1'b1, "itype_no_sub");
        step(mk(7'b1111111, 3'b111, 7'h7F), 1'b0, "hold_en0");
        step(mk(7'b1111111, 3'b111, 7'h7F), 1'b1, "bubble_ff");
        step(mk(7'b0110011, 3'b111, 7'h00), 1'b1, "rtype_and");
        step(mk(7'b0010011, 3'b011, 7'h00), 1'b1, "itype_sltu");

        // Reset dropped mid-stream between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = '0;
        check("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(7'b0000011, 3'b000, 7'h00), 1'b1, "after_reset");

        // Randomized stream with random enable
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 5) != 5) begin
                opc = opcs[$urandom_range(0, 4)];
                ins[31:25] = opc;
                if ($urandom_range(0, 2) == 0) ins[6:0] = 7'b0100000;
            end
            step(ins, ($urandom_range(0, 3) != 0), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
